max_track_8: RTL and testbench
==============================

MAX_TRACK_8 -- requirements
Module: max_track_8

Interface
REQ-001 SHALL have parameter: IDX_W, default 8, width of sample index/count.
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample present.
- in_ready  output  1  block accepts sample this cycle.
- in_data  input  8  unsigned sample.
- in_last  input  1  sample is final in frame.
- cmp_a  output  8  comparator operand A, combinationally equal to in_data.
- cmp_b  output  8  comparator operand B, combinationally equal to stored max.
- cmp_eq  input  1  external 8-bit comparator result, A==B, same cycle; cascade inputs e0=1, g0=0.
- cmp_gt  input  1  external comparator result, A>B, same cycle.
- res_valid  output  1  frame result held.
- res_ready  input  1  consumer takes result.
- max_val  output  8  frame maximum.
- max_idx  output  IDX_W  index of first occurrence of maximum.
- cnt  output  IDX_W  samples accepted in frame, saturating.
- ovf  output  1  frame exceeded 2^IDX_W-1 samples.
- eq_cnt  output  IDX_W  ties with running max; present only with TIE_COUNT_EN.

Function
REQ-003 SHALL implement FSM states FIRST, ACCUM, RESULT; a transfer occurs when in_valid && in_ready.
REQ-004 SHALL drive in_ready=1 in FIRST and ACCUM, in_ready=0 in RESULT.
REQ-005 SHALL, on a transfer in FIRST, load max_val=in_data, max_idx=0, cnt=1, ovf=0 without using cmp_eq/cmp_gt, then go to ACCUM.
REQ-006 SHALL, on a transfer in ACCUM with cmp_gt=1, load max_val=in_data, max_idx=cnt.
REQ-007 SHALL, on a transfer in ACCUM with cmp_gt=0, leave max_val/max_idx unchanged; equal values keep the earliest index.
REQ-008 SHALL increment cnt on every transfer, saturating at 2^IDX_W-1; a transfer while cnt is saturated sets ovf=1 and leaves max_idx updates clamped at 2^IDX_W-1.
REQ-009 SHALL, on a transfer with in_last=1 in FIRST or ACCUM, apply that sample's update, then enter RESULT with res_valid=1 on the next cycle (one-cycle latency).
REQ-010 SHALL hold max_val, max_idx, cnt, ovf, eq_cnt stable while res_valid=1.
REQ-011 SHALL, in RESULT with res_ready=1, return to FIRST and deassert res_valid the following cycle; outputs retain values until the next FIRST load.
REQ-012 SHALL ignore in_valid, in_data, in_last when no transfer occurs; idle cycles in ACCUM change nothing.
REQ-013 SHALL not register cmp_a/cmp_b; the comparator path is combinational within one cycle.

Reset
REQ-014 SHALL, when rst=1 at a clock edge, enter FIRST and clear res_valid, max_val, max_idx, cnt, ovf, eq_cnt to 0, overriding any simultaneous transfer or res_ready.
REQ-015 SHALL discard a partial frame when reset mid-frame or mid-RESULT; no result is produced for it.

Configuration
REQ-016 SHALL compile the tie counter only when macro MAX_TRACK_TIE_COUNT_EN is defined: eq_cnt resets to 0 at FIRST load, increments (saturating) on ACCUM transfers with cmp_eq=1, and resets to 0 when cmp_gt=1.
REQ-017 SHALL, without MAX_TRACK_TIE_COUNT_EN, omit the eq_cnt port and ignore cmp_eq entirely; all other behaviour is identical.

Verification
REQ-018 SHALL cover frame 5,9,3,9(last): res_valid one cycle after last; max_val=9, max_idx=1, cnt=4, eq_cnt=1 if enabled.
REQ-019 SHALL cover single-sample frame 0x80 with in_last on first transfer: max_val=0x80, max_idx=0, cnt=1.
REQ-020 SHALL cover res_ready held 0 for 3 cycles while in_valid=1: in_ready=0, outputs stable, no sample consumed; res_ready=1 clears res_valid next cycle.
REQ-021 SHALL cover 300-sample frame of 0x00 with 0xFF at index 270, IDX_W=8: cnt=255, ovf=1, max_val=0xFF, max_idx=255.
REQ-022 SHALL cover rst pulse after 2 samples of a frame, then frame 7(last): max_val=7, max_idx=0, cnt=1, ovf=0.

Source files
------------

// File: rtl/max_track_8.sv
// -----------------------------------------------------------------------------
// max_track_8 -- per-frame maximum tracker with an external comparator.
//
// Accepts a stream of unsigned 8-bit samples grouped into frames (in_last marks
// the final sample). For each frame it reports the maximum value, the index of
// its first occurrence, the number of samples seen (saturating) and an overflow
// flag. The magnitude comparison itself is done outside the block: in_data and
// the stored maximum are presented combinationally on cmp_a/cmp_b and the
// comparator answers on cmp_eq/cmp_gt in the same cycle.
//
// Optional feature: define MAX_TRACK_TIE_COUNT_EN to build the tie counter
// (eq_cnt port). Without it eq_cnt is absent and cmp_eq is ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   sample handshake; in_data sample, in_last end of frame
//   cmp_a, cmp_b        comparator operands (in_data, stored max)
//   cmp_eq, cmp_gt      comparator results for cmp_a vs cmp_b
//   res_valid/res_ready result handshake
//   max_val, max_idx    frame maximum and index of its first occurrence
//   cnt, ovf            accepted-sample count (saturating), overflow flag
//   eq_cnt              ties with the running maximum (tie counter build only)
// -----------------------------------------------------------------------------
module max_track_8 #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic [7:0]       cmp_a,
  output logic [7:0]       cmp_b,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       max_val,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] cnt,
  output logic             ovf
`ifdef MAX_TRACK_TIE_COUNT_EN
  ,
  output logic [IDX_W-1:0] eq_cnt
`endif
);

  localparam logic [IDX_W-1:0] CNT_MAX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t state;

  logic             xfer;
  logic             cnt_sat;
  logic [IDX_W-1:0] cnt_nxt;

  assign in_ready = (state != RESULT);
  assign xfer     = in_valid && in_ready;

  // Comparator path is purely combinational; the answer is used in the same cycle.
  assign cmp_a = in_data;
  assign cmp_b = max_val;

  assign cnt_sat = (cnt == CNT_MAX);
  assign cnt_nxt = cnt_sat ? cnt : cnt + CNT_ONE;

`ifndef MAX_TRACK_TIE_COUNT_EN
  logic unused_cmp_eq;
  assign unused_cmp_eq = cmp_eq;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FIRST;
      res_valid <= 1'b0;
      max_val   <= '0;
      max_idx   <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
`ifdef MAX_TRACK_TIE_COUNT_EN
      eq_cnt    <= '0;
`endif
    end else begin
      case (state)
        FIRST: begin
          // First sample of a frame is the maximum by definition; no comparison.
          if (xfer) begin
            max_val <= in_data;
            max_idx <= '0;
            cnt     <= CNT_ONE;
            ovf     <= 1'b0;
`ifdef MAX_TRACK_TIE_COUNT_EN
            eq_cnt  <= '0;
`endif
            if (in_last) begin
              state     <= RESULT;
              res_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (xfer) begin
            // Strictly greater only: ties keep the earliest index. The current
            // count is the index of this sample, already clamped by saturation.
            if (cmp_gt) begin
              max_val <= in_data;
              max_idx <= cnt;
            end
            cnt <= cnt_nxt;
            if (cnt_sat) ovf <= 1'b1;
`ifdef MAX_TRACK_TIE_COUNT_EN
            if (cmp_gt)
              eq_cnt <= '0;
            else if (cmp_eq && (eq_cnt != CNT_MAX))
              eq_cnt <= eq_cnt + CNT_ONE;
`endif
            if (in_last) begin
              state     <= RESULT;
              res_valid <= 1'b1;
            end
          end
        end

        RESULT: begin
          // Result registers stay put here and after release, until the next
          // frame's first sample reloads them.
          if (res_ready) begin
            state     <= FIRST;
            res_valid <= 1'b0;
          end
        end

        default: begin
          state     <= FIRST;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_track_8.sv
// -----------------------------------------------------------------------------
// Testbench for max_track_8: scoreboard with a queue of expected frame results
// produced by a reference model that works on whole sample lists. A monitor
// process pops one entry whenever a new result appears and also checks that a
// held result stays stable and clears after it is taken.
// -----------------------------------------------------------------------------
module tb_max_track_8;

  localparam int IDX_W = 8;
  localparam int MAXC  = (1 << IDX_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic [7:0]       cmp_a;
  logic [7:0]       cmp_b;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       max_val;
  logic [IDX_W-1:0] max_idx;
  logic [IDX_W-1:0] cnt;
  logic             ovf;
`ifdef MAX_TRACK_TIE_COUNT_EN
  logic [IDX_W-1:0] eq_cnt;
`endif

  max_track_8 #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_eq    (cmp_eq),
    .cmp_gt    (cmp_gt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .max_val   (max_val),
    .max_idx   (max_idx),
    .cnt       (cnt),
    .ovf       (ovf)
`ifdef MAX_TRACK_TIE_COUNT_EN
    ,
    .eq_cnt    (eq_cnt)
`endif
  );

  // External 8-bit magnitude comparator.
  assign cmp_eq = (cmp_a == cmp_b);
  assign cmp_gt = (cmp_a > cmp_b);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int v;
    int idx;
    int c;
    int o;
    int e;
    int cy;
  } exp_t;

  exp_t exp_q[$];
  int   samples[$];

  // Reference model: evaluates a complete frame from its sample list.
  function automatic exp_t model(input int cy);
    exp_t r;
    int n, first;
    n = samples.size();
    r.v = -1;
    first = 0;
    foreach (samples[i]) if (samples[i] > r.v) begin r.v = samples[i]; first = i; end
    r.c   = (n > MAXC) ? MAXC : n;
    r.o   = (n > MAXC) ? 1 : 0;
    r.idx = (first > MAXC) ? MAXC : first;
    r.e   = 0;
    for (int j = first + 1; j < n; j++) if (samples[j] == r.v) r.e++;
    if (r.e > MAXC) r.e = MAXC;
    r.cy  = cy;
    return r;
  endfunction

  // Consumer: random back-pressure on res_ready unless forced low.
  bit force_low = 1'b0;
  bit done = 1'b0;
  initial begin
    res_ready = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      res_ready = force_low ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit   prev_v = 1'b0, exp_clr = 1'b0, rst_prev = 1'b1;
    exp_t snap, e;
    snap = '{default: 0};
    while (!done) begin
      @(negedge clk);
      if (!rst_prev) begin
        if (exp_clr) check("res_clear", int'(res_valid), 0);
        if (res_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            check("spurious_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("latency_cycle", cyc, e.cy);
            check("max_val", int'(max_val), e.v);
            check("max_idx", int'(max_idx), e.idx);
            check("cnt", int'(cnt), e.c);
            check("ovf", int'(ovf), e.o);
`ifdef MAX_TRACK_TIE_COUNT_EN
            check("eq_cnt", int'(eq_cnt), e.e);
`endif
          end
          snap.v = max_val; snap.idx = max_idx; snap.c = cnt; snap.o = ovf;
`ifdef MAX_TRACK_TIE_COUNT_EN
          snap.e = eq_cnt;
`endif
        end else if (res_valid && prev_v) begin
          check("hold_max_val", int'(max_val), snap.v);
          check("hold_max_idx", int'(max_idx), snap.idx);
          check("hold_cnt", int'(cnt), snap.c);
          check("hold_ovf", int'(ovf), snap.o);
`ifdef MAX_TRACK_TIE_COUNT_EN
          check("hold_eq_cnt", int'(eq_cnt), snap.e);
`endif
        end
      end
      exp_clr  = res_valid && res_ready && !rst;
      prev_v   = res_valid;
      rst_prev = rst;
    end
  end

  // Drive one sample and wait (bounded) for it to be accepted.
  task automatic send(input int d, input bit l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    samples.push_back(d);
    if (l) begin
      exp_q.push_back(model(cyc));
      samples.delete();
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      in_data = 8'($urandom);
      in_last = 1'($urandom);
    end
  endtask

  task automatic do_reset(input int k);
    rst = 1'b1;
    repeat (k) begin @(posedge clk); #1; end
    rst = 1'b0;
    samples.delete();
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_max_val", int'(max_val), 0);
    check("rst_max_idx", int'(max_idx), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_in_ready", int'(in_ready), 1);
`ifdef MAX_TRACK_TIE_COUNT_EN
    check("rst_eq_cnt", int'(eq_cnt), 0);
`endif
  endtask

  initial begin
    int len, w;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);

    // Frame 5,9,3,9: max 9 at index 1, four samples, one tie.
    send(5, 0); send(9, 0); send(3, 0); send(9, 1);
    idle(2);

    // Single-sample frame.
    send(8'h80, 1);
    idle(2);

    // Result held while the producer waits: no sample may be consumed.
    force_low = 1'b1;
    idle(1);
    send(1, 0); send(2, 1);
    in_valid = 1'b1; in_data = 8'h33; in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_res_valid", int'(res_valid), 1);
    end
    force_low = 1'b0;
    send(8'h33, 1);
    idle(3);

    // 300-sample frame, 0xFF at index 270: count and index saturate.
    for (int i = 0; i < 300; i++) send((i == 270) ? 8'hFF : 8'h00, (i == 299));
    idle(2);

    // Reset mid-frame discards the partial frame.
    send(200, 0); send(100, 0);
    do_reset(1);
    send(7, 1);
    idle(2);

    // Reset while a result is held.
    force_low = 1'b1;
    idle(1);
    send(50, 0); send(60, 1);
    idle(2);
    do_reset(1);
    force_low = 1'b0;

    // Randomized frames with idle gaps and small value ranges for ties.
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 9) == 0) ? 1 : $urandom_range(2, 12);
      for (int i = 0; i < len; i++) begin
        w = (f % 3 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
        send(w, i == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end

    // Drain: every expected result must have been observed.
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    end
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
